nr_crc_attach: RTL and testbench
================================

# nr_crc_attach

Multi-polynomial serial CRC generator for the PUSCH transmit chain, the next generation of the fixed 16-bit serial CRC block. It computes any 3GPP TS 38.212 CRC (24A/24B/24C/16/11/6), with the polynomial selected per transport block. Data passes through with one cycle of latency and the CRC is appended serially, MSB first, directly after the last data bit. It sits between the transport-block source and code-block segmentation.

## Interface
- MAX_W, 24: width of the internal LFSR and of CRC_OUT; must be ≥ the longest enabled CRC.
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- IN_VALID  in  1  IN_DATA is valid this cycle.
- IN_DATA  in  1  serial data bit, block MSB first.
- IN_LAST  in  1  qualifies the final data bit of the block.
- IN_READY  out  1  block accepts a bit; a bit transfers when IN_VALID && IN_READY.
- MODE  in  3  0=CRC24A 0x864CFB, 1=CRC24B 0x800063, 2=CRC24C 0xB2B117, 3=CRC16 0x1021, 4=CRC11 0x621, 5=CRC6 0x21; 6,7 are treated as CRC16.
- OUT_VALID  out  1  OUT_DATA valid.
- OUT_DATA  out  1  data bit or CRC bit.
- OUT_LAST  out  1  final CRC bit of the block.
- CRC_OUT  out  MAX_W  final remainder, right-aligned, zero-extended.
- CRC_VALID  out  1  one-cycle pulse, coincident with OUT_LAST.
- BUSY  out  1  state ≠ IDLE.

## Operation
- States:
  - IDLE: IN_READY=1.
  - DATA: IN_READY=1.
  - APPEND: IN_READY=0.
- Transitions:
  - IDLE→DATA on the first accepted bit. MODE is latched on that bit; MODE changes later in the block are ignored.
  - IDLE/DATA→APPEND on an accepted bit with IN_LAST=1. A 1-bit block goes IDLE→APPEND directly.
  - APPEND→IDLE after L bits, where L is the latched CRC length.
- LFSR, seed all zeros, cleared on every IDLE exit:
  - fb = IN_DATA ^ lfsr[L-1]
  - lfsr ← ((lfsr<<1) ^ (fb ? POLY : 0)) masked to L bits.
- IN_VALID gaps inside DATA are legal. The LFSR holds and OUT_VALID is 0 during a gap.
- APPEND emits lfsr[L-1] and shifts left with zero fill. A down-counter runs from L-1 to 0, and OUT_LAST asserts at count 0.
- CRC_OUT is loaded with the final remainder on the edge that accepts the IN_LAST bit. It holds until the next block's IN_LAST.
- Reset values: state IDLE, LFSR 0, counter 0. All outputs are 0 except IN_READY. IN_READY is 1 one cycle after reset release; it is combinational from state.
- Reset mid-block aborts the block with no CRC_VALID. Partial output is discarded downstream.

## Timing
- A bit accepted at edge k appears on OUT_DATA/OUT_VALID after edge k.
- IN_LAST is accepted at edge n.
  - CRC bits occupy the cycles after edges n+1 … n+L.
  - The output stream is gapless when input had no gaps.
  - OUT_LAST and CRC_VALID are asserted after edge n+L.
- The state is IDLE after edge n+L, so the next block's first bit can be accepted at edge n+L+1.
- Per-block overhead is L cycles.

## Configuration
- NR_CRC_CHECK_EN defined:
  - Adds input CHECK (1), latched with MODE, and output CRC_OK (1), which pulses with CRC_VALID.
  - With CHECK=1, the input is data followed by the received CRC, with IN_LAST on the final CRC bit.
  - In this mode there is no APPEND phase. OUT_LAST, CRC_VALID and CRC_OK assert after edge n+1.
  - CRC_OK=1 iff the remainder is 0.
- NR_CRC_CHECK_EN undefined:
  - CHECK and CRC_OK ports are absent; the block is generate-only.

## Structure
- Package nr_crc_pkg holds:
  - the mode enum crc_mode_t;
  - the POLY and LEN constants per mode;
  - the state enum.
- Sub-module nr_crc_lfsr is the MAX_W-bit masked Galois LFSR with a runtime POLY/LEN step. It is reused by the CRC check on the receive side.
- The top holds the FSM, the counter and the output register.

## Test plan
- CRC16, single bit 1 → OUT stream is 1 then 0x1021 MSB first. CRC_OUT=0x1021, and CRC_VALID aligns with OUT_LAST after edge n+16.
- Each mode, single bit 1 → CRC_OUT equals the mode POLY (0x864CFB, 0x800063, 0xB2B117, 0x1021, 0x621, 0x21). The counter covers L=24/16/11/6.
- CRC24A, 1024 random bits with random IN_VALID gaps → CRC_OUT matches the reference model. OUT_VALID has no pulses during gaps.
- Back-to-back blocks, CRC6 then CRC24B, with MODE toggled mid-block → each CRC uses its latched mode. IN_READY is low exactly L cycles. The second block starts at edge n+L+1.
- RST asserted during APPEND → all outputs 0 immediately and no CRC_VALID. The next block's CRC matches a fresh model.
- NR_CRC_CHECK_EN, CRC11 data+correct CRC → CRC_OK=1. With one bit flipped → CRC_OK=0.

Source files
------------

// File: rtl/nr_crc_pkg.sv
// Shared types and constants for the multi-polynomial NR CRC attach/check slice.
// Optional receive-side check mode is enabled by NR_CRC_CHECK_EN.
package nr_crc_pkg;

    localparam int unsigned MAX_W_DEF = 24;
    localparam int unsigned LEN_W     = 5;

    typedef enum logic [2:0] {
        CRC24A = 3'd0,
        CRC24B = 3'd1,
        CRC24C = 3'd2,
        CRC16  = 3'd3,
        CRC11  = 3'd4,
        CRC6   = 3'd5
    } crc_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_APPEND = 2'd2
    } state_t;

    // Generator polynomial without the x^L term; codes 6 and 7 fall back to CRC16.
    function automatic logic [MAX_W_DEF-1:0] crc_poly(input logic [2:0] mode);
        case (crc_mode_t'(mode))
            CRC24A:  crc_poly = 24'h864CFB;
            CRC24B:  crc_poly = 24'h800063;
            CRC24C:  crc_poly = 24'hB2B117;
            CRC11:   crc_poly = 24'h000621;
            CRC6:    crc_poly = 24'h000021;
            default: crc_poly = 24'h001021;
        endcase
    endfunction

    function automatic logic [LEN_W-1:0] crc_len(input logic [2:0] mode);
        case (crc_mode_t'(mode))
            CRC24A, CRC24B, CRC24C: crc_len = LEN_W'(24);
            CRC11:                  crc_len = LEN_W'(11);
            CRC6:                   crc_len = LEN_W'(6);
            default:                crc_len = LEN_W'(16);
        endcase
    endfunction

endpackage

// File: rtl/nr_crc_attach_if.sv
// Serial bit-stream bus between the transport-block source, the CRC block and segmentation.
// CHECK/CRC_OK exist only when NR_CRC_CHECK_EN is defined.
interface nr_crc_attach_if #(
    parameter int unsigned MAX_W = 24
) ();
    logic             IN_VALID;
    logic             IN_DATA;
    logic             IN_LAST;
    logic             IN_READY;
    logic [2:0]       MODE;
    logic             OUT_VALID;
    logic             OUT_DATA;
    logic             OUT_LAST;
    logic [MAX_W-1:0] CRC_OUT;
    logic             CRC_VALID;
    logic             BUSY;
`ifdef NR_CRC_CHECK_EN
    logic             CHECK;
    logic             CRC_OK;

    modport master (
        output IN_VALID, IN_DATA, IN_LAST, MODE, CHECK,
        input  IN_READY, OUT_VALID, OUT_DATA, OUT_LAST, CRC_OUT, CRC_VALID, BUSY, CRC_OK
    );
    modport slave (
        input  IN_VALID, IN_DATA, IN_LAST, MODE, CHECK,
        output IN_READY, OUT_VALID, OUT_DATA, OUT_LAST, CRC_OUT, CRC_VALID, BUSY, CRC_OK
    );
`else
    modport master (
        output IN_VALID, IN_DATA, IN_LAST, MODE,
        input  IN_READY, OUT_VALID, OUT_DATA, OUT_LAST, CRC_OUT, CRC_VALID, BUSY
    );
    modport slave (
        input  IN_VALID, IN_DATA, IN_LAST, MODE,
        output IN_READY, OUT_VALID, OUT_DATA, OUT_LAST, CRC_OUT, CRC_VALID, BUSY
    );
`endif
endinterface

// File: rtl/nr_crc_lfsr.sv
// W-bit masked Galois CRC LFSR with runtime polynomial and length; shared with the receive-side checker.
module nr_crc_lfsr
    import nr_crc_pkg::*;
#(
    parameter int unsigned W = 24
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             step,
    input  logic             seed_zero,
    input  logic             din,
    input  logic [W-1:0]     poly,
    input  logic [LEN_W-1:0] len,
    output logic [W-1:0]     next_c,
    output logic             msb_c
);
    logic [W-1:0] lfsr_q;
    logic [W-1:0] base;
    logic [W-1:0] mask;
    logic         fb;

    // A step from IDLE starts from the all-zero seed rather than the leftover remainder.
    always_comb begin
        base   = seed_zero ? '0 : lfsr_q;
        mask   = (W'(1) << len) - W'(1);
        msb_c  = |(base & (W'(1) << (len - LEN_W'(1))));
        fb     = din ^ msb_c;
        next_c = ((base << 1) ^ (fb ? poly : '0)) & mask;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)      lfsr_q <= '0;
        else if (step) lfsr_q <= next_c;
    end

endmodule

// File: rtl/nr_crc_attach.sv
// Serial multi-polynomial CRC attach: one-cycle data pass-through then MSB-first CRC append.
// Defining NR_CRC_CHECK_EN adds a per-block CHECK mode that reports CRC_OK instead of appending.
module nr_crc_attach
    import nr_crc_pkg::*;
#(
    parameter int unsigned MAX_W = MAX_W_DEF
) (
    input  logic            CLK,
    input  logic            RST,
    nr_crc_attach_if.slave  bus
);
    state_t             state_q, state_d;
    logic [MAX_W-1:0]   poly_q, cur_poly;
    logic [LEN_W-1:0]   len_q, cur_len;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               chk_q, chk_cur;
    logic               in_idle, accept;
    logic               lfsr_step, lfsr_din, lfsr_msb;
    logic [MAX_W-1:0]   lfsr_nxt;

    logic               out_valid_q, out_valid_d;
    logic               out_data_q,  out_data_d;
    logic               out_last_q,  out_last_d;
    logic               crc_valid_q, crc_valid_d;
    logic [MAX_W-1:0]   crc_out_q;
    logic               crc_ld;
    logic               busy_q;

    assign in_idle      = (state_q == ST_IDLE);
    assign bus.IN_READY = (state_q != ST_APPEND);
    assign accept       = bus.IN_VALID && bus.IN_READY;

    // Mode is taken live on the first bit of a block and from the latched copy afterwards.
    assign cur_poly = in_idle ? MAX_W'(crc_poly(bus.MODE)) : poly_q;
    assign cur_len  = in_idle ? crc_len(bus.MODE) : len_q;
`ifdef NR_CRC_CHECK_EN
    assign chk_cur  = in_idle ? bus.CHECK : chk_q;
`else
    assign chk_cur  = 1'b0;
`endif

    // Appending feeds the LFSR its own MSB, so feedback cancels and it shifts out with zero fill.
    assign lfsr_step = accept || (state_q == ST_APPEND);
    assign lfsr_din  = (state_q == ST_APPEND) ? lfsr_msb : bus.IN_DATA;

    nr_crc_lfsr #(.W(MAX_W)) u_lfsr (
        .CLK       (CLK),
        .RST       (RST),
        .step      (lfsr_step),
        .seed_zero (in_idle),
        .din       (lfsr_din),
        .poly      (cur_poly),
        .len       (cur_len),
        .next_c    (lfsr_nxt),
        .msb_c     (lfsr_msb)
    );

`ifdef NR_CRC_CHECK_EN
    logic fin_q, fin_d;
    logic ok_q,  ok_d;
    logic crc_ok_q;
    assign fin_d      = accept && bus.IN_LAST && chk_cur;
    assign ok_d       = (lfsr_nxt == '0);
    assign bus.CRC_OK = crc_ok_q;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_data_d  = 1'b0;
        out_last_d  = 1'b0;
        crc_valid_d = 1'b0;
        crc_ld      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DATA: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = bus.IN_DATA;
                    state_d     = ST_DATA;
                    if (bus.IN_LAST) begin
                        crc_ld = 1'b1;
                        if (chk_cur) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_APPEND;
                            cnt_d   = cur_len - LEN_W'(1);
                        end
                    end
                end
            end
            ST_APPEND: begin
                out_valid_d = 1'b1;
                out_data_d  = lfsr_msb;
                cnt_d       = cnt_q - LEN_W'(1);
                if (cnt_q == '0) begin
                    out_last_d  = 1'b1;
                    crc_valid_d = 1'b1;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef NR_CRC_CHECK_EN
        if (fin_q) begin
            out_last_d  = 1'b1;
            crc_valid_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            poly_q      <= '0;
            len_q       <= '0;
            chk_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
            out_last_q  <= 1'b0;
            crc_valid_q <= 1'b0;
            crc_out_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            if (accept && in_idle) begin
                poly_q <= cur_poly;
                len_q  <= cur_len;
                chk_q  <= chk_cur;
            end
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            crc_valid_q <= crc_valid_d;
            if (crc_ld) crc_out_q <= lfsr_nxt;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

`ifdef NR_CRC_CHECK_EN
    // Check verdict is reported one cycle after the final received CRC bit.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fin_q    <= 1'b0;
            ok_q     <= 1'b0;
            crc_ok_q <= 1'b0;
        end else begin
            fin_q    <= fin_d;
            if (fin_d) ok_q <= ok_d;
            crc_ok_q <= fin_q && ok_q;
        end
    end
`endif

    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT_DATA  = out_data_q;
    assign bus.OUT_LAST  = out_last_q;
    assign bus.CRC_VALID = crc_valid_q;
    assign bus.CRC_OUT   = crc_out_q;
    assign bus.BUSY      = busy_q;

endmodule

// File: tb/tb_nr_crc_attach.sv
// Self-checking bench for nr_crc_attach: per-mode vector table plus scoreboarded block sequences.
// Exercises the CHECK path as well when NR_CRC_CHECK_EN is defined.
module tb_nr_crc_attach;

    typedef bit bitq_t[$];
    typedef struct { logic [2:0] mode; int len; logic [23:0] crc; } vec_t;
    typedef struct { logic [23:0] crc; logic ok; } crc_exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    nr_crc_attach_if #(.MAX_W(24)) bus ();
    nr_crc_attach #(.MAX_W(24)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    logic [1:0] sb[$];
    crc_exp_t   crcq[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         beats = 0;
    int         last_wait = 0;
    logic       cur_chk = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int len_of(input logic [2:0] m);
        case (m)
            3'd0, 3'd1, 3'd2: return 24;
            3'd4:             return 11;
            3'd5:             return 6;
            default:          return 16;
        endcase
    endfunction

    function automatic logic [23:0] poly_of(input logic [2:0] m);
        case (m)
            3'd0:    return 24'h864CFB;
            3'd1:    return 24'h800063;
            3'd2:    return 24'hB2B117;
            3'd4:    return 24'h000621;
            3'd5:    return 24'h000021;
            default: return 24'h001021;
        endcase
    endfunction

    // Polynomial long division of msg * x^L by the full generator.
    function automatic logic [23:0] crc_ref(input bitq_t msg, input logic [2:0] m);
        int          L = len_of(m);
        logic [24:0] g = (25'd1 << L) | {1'b0, poly_of(m)};
        logic [24:0] r = '0;
        logic        b;
        for (int i = 0; i < msg.size() + L; i++) begin
            b = (i < msg.size()) ? logic'(msg[i]) : 1'b0;
            r = (r << 1) | {24'd0, b};
            if (r[L]) r = r ^ g;
        end
        return r[23:0];
    endfunction

    task automatic drive_bit(input logic b, input logic l, input logic [2:0] m, input logic chk);
        int   n = 0;
        logic rdy;
        bus.IN_VALID = 1'b1;
        bus.IN_DATA  = b;
        bus.IN_LAST  = l;
        bus.MODE     = m;
        cur_chk      = chk;
`ifdef NR_CRC_CHECK_EN
        bus.CHECK    = chk;
`endif
        do begin
            rdy = bus.IN_READY;
            @(posedge CLK);
            #1;
            n++;
        end while (!rdy && n < 200);
        if (!rdy) check("accept_timeout", 32'(n), 32'(0));
        last_wait    = n;
        bus.IN_VALID = 1'b0;
        bus.IN_LAST  = 1'b0;
    endtask

    task automatic send_block(input logic [2:0] m, input logic chk, input bitq_t bits,
                              input int maxgap, input bit toggle);
        logic [23:0] r;
        int          L;
        logic [2:0]  mm;
        crc_exp_t    e;
        int          first_wait;
        L = len_of(m);
        r = crc_ref(bits, m);
        foreach (bits[i]) sb.push_back({logic'(bits[i]), 1'b0});
        if (!chk) for (int j = L - 1; j >= 0; j--) sb.push_back({r[j], logic'(j == 0)});
        e.crc = r;
        e.ok  = (r == 24'd0);
        crcq.push_back(e);
        first_wait = 0;
        for (int i = 0; i < bits.size(); i++) begin
            if (i > 0 && maxgap > 0)
                repeat ($urandom_range(0, maxgap)) begin @(posedge CLK); #1; end
            mm = (i > 0 && toggle) ? 3'($urandom_range(0, 7)) : m;
            drive_bit(logic'(bits[i]), logic'(i == bits.size() - 1), mm, chk);
            if (i == 0) first_wait = last_wait;
        end
        last_wait = first_wait;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || crcq.size() != 0) && n < 400) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("drain", 32'(sb.size() + crcq.size()), 32'(0));
    endtask

    task automatic count_ready_low(output int c);
        c = 0;
        while (!bus.IN_READY && c < 100) begin
            c++;
            @(posedge CLK);
            #1;
        end
    endtask

    vec_t  vecs[8];
    bitq_t q;
    int    c;

    initial begin
        vecs[0] = '{3'd0, 24, 24'h864CFB};
        vecs[1] = '{3'd1, 24, 24'h800063};
        vecs[2] = '{3'd2, 24, 24'hB2B117};
        vecs[3] = '{3'd3, 16, 24'h001021};
        vecs[4] = '{3'd4, 11, 24'h000621};
        vecs[5] = '{3'd5,  6, 24'h000021};
        vecs[6] = '{3'd6, 16, 24'h001021};
        vecs[7] = '{3'd7, 16, 24'h001021};

        bus.IN_VALID = 1'b0;
        bus.IN_DATA  = 1'b0;
        bus.IN_LAST  = 1'b0;
        bus.MODE     = 3'd0;
`ifdef NR_CRC_CHECK_EN
        bus.CHECK    = 1'b0;
`endif

        // Output monitor: every valid beat and every CRC pulse is matched against the scoreboard.
        fork
            forever begin
                crc_exp_t ce;
                logic [1:0] eb;
                @(negedge CLK);
                if (RST) begin
                    if (bus.OUT_VALID) begin
                        beats++;
                        if (sb.size() == 0) check("extra_beat", 32'(1), 32'(0));
                        else begin
                            eb = sb.pop_front();
                            check("out_bit", 32'({bus.OUT_DATA, bus.OUT_LAST}), 32'(eb));
                        end
                    end
                    if (bus.CRC_VALID || bus.OUT_LAST)
                        check("valid_last_align", 32'(bus.CRC_VALID), 32'(bus.OUT_LAST));
                    if (bus.CRC_VALID) begin
                        if (crcq.size() == 0) check("extra_crc", 32'(1), 32'(0));
                        else begin
                            ce = crcq.pop_front();
                            check("crc_out", 32'(bus.CRC_OUT), 32'(ce.crc));
`ifdef NR_CRC_CHECK_EN
                            check("crc_ok", 32'(bus.CRC_OK), 32'(ce.ok));
`endif
                        end
                    end
                end
            end
        join_none

        #3 RST = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_out_valid", 32'(bus.OUT_VALID), 32'(0));
        check("rst_out_last",  32'(bus.OUT_LAST),  32'(0));
        check("rst_crc_valid", 32'(bus.CRC_VALID), 32'(0));
        check("rst_crc_out",   32'(bus.CRC_OUT),   32'(0));
        check("rst_busy",      32'(bus.BUSY),      32'(0));
        RST = 1'b1;
        @(posedge CLK);
        #1;
        check("rst_in_ready", 32'(bus.IN_READY), 32'(1));

        // Single '1' bit per mode: remainder equals the generator polynomial.
        for (int v = 0; v < 8; v++) begin
            q.delete();
            q.push_back(1'b1);
            beats = 0;
            send_block(vecs[v].mode, 1'b0, q, 0, 1'b0);
            check("busy_in_append", 32'(bus.BUSY), 32'(1));
            wait_drain();
            check("tab_crc", 32'(bus.CRC_OUT), 32'(vecs[v].crc));
            check("tab_beats", 32'(beats), 32'(1 + vecs[v].len));
        end

        // CRC24A, long random block with input gaps.
        q.delete();
        for (int i = 0; i < 1024; i++) q.push_back(1'($urandom_range(0, 1)));
        beats = 0;
        send_block(3'd0, 1'b0, q, 3, 1'b0);
        wait_drain();
        check("rand_beats", 32'(beats), 32'(1024 + 24));

        // Back-to-back CRC6 then CRC24B, MODE scrambled after the first bit.
        q.delete();
        for (int i = 0; i < 20; i++) q.push_back(1'($urandom_range(0, 1)));
        send_block(3'd5, 1'b0, q, 0, 1'b1);
        count_ready_low(c);
        check("ready_low_crc6", 32'(c), 32'(6));
        q.delete();
        for (int i = 0; i < 30; i++) q.push_back(1'($urandom_range(0, 1)));
        send_block(3'd1, 1'b0, q, 0, 1'b1);
        check("b2b_first_accept", 32'(last_wait), 32'(1));
        count_ready_low(c);
        check("ready_low_crc24b", 32'(c), 32'(24));
        wait_drain();

        // Reset while the CRC is being appended.
        q.delete();
        for (int i = 0; i < 8; i++) q.push_back(1'($urandom_range(0, 1)));
        send_block(3'd3, 1'b0, q, 0, 1'b0);
        repeat (3) begin @(posedge CLK); #1; end
        RST = 1'b0;
        #1;
        sb.delete();
        crcq.delete();
        check("abort_out_valid", 32'(bus.OUT_VALID), 32'(0));
        check("abort_out_data",  32'(bus.OUT_DATA),  32'(0));
        check("abort_crc_valid", 32'(bus.CRC_VALID), 32'(0));
        check("abort_crc_out",   32'(bus.CRC_OUT),   32'(0));
        check("abort_busy",      32'(bus.BUSY),      32'(0));
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        q.delete();
        for (int i = 0; i < 40; i++) q.push_back(1'($urandom_range(0, 1)));
        send_block(3'd2, 1'b0, q, 1, 1'b0);
        wait_drain();

`ifdef NR_CRC_CHECK_EN
        // CRC11 check: data followed by its own CRC, then the same stream with one bit flipped.
        begin
            logic [23:0] r;
            q.delete();
            for (int i = 0; i < 15; i++) q.push_back(1'($urandom_range(0, 1)));
            r = crc_ref(q, 3'd4);
            for (int j = 10; j >= 0; j--) q.push_back(bit'(r[j]));
            send_block(3'd4, 1'b1, q, 0, 1'b0);
            wait_drain();
            q[3] = ~q[3];
            send_block(3'd4, 1'b1, q, 0, 1'b0);
            wait_drain();
        end
`endif

        repeat (4) @(posedge CLK);
        #1;
        check("sb_empty", 32'(sb.size() + crcq.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
